csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
REQ-002 Parameter VECTORED_EN, 1, 1 enables mtvec vectored mode (MODE=1); 0 forces MODE=0.
REQ-003 Parameter COUNTERS_EN, 1, 1 implements mcycle/minstret; 0 makes them read-zero and ignores writes.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 csr_en_i  input  1  CSR instruction valid this cycle.
REQ-007 csr_op_i  input  2  00 read-only, 01 RW, 10 RS (set bits), 11 RC (clear bits).
REQ-008 csr_addr_i  input  12  CSR address.
REQ-009 csr_wdata_i  input  32  write operand (rs1 or zimm).
REQ-010 csr_rdata_o  output  32  old CSR value, combinational.
REQ-011 csr_illegal_o  output  1  illegal CSR access flag, combinational.
REQ-012 instret_i  input  1  one instruction retired this cycle.
REQ-013 trap_i  input  1  take exception/interrupt this cycle.
REQ-014 pc_i  input  32  PC of trapping instruction.
REQ-015 cause_i  input  32  mcause value; bit 31 = interrupt.
REQ-016 tval_i  input  32  mtval value.
REQ-017 mret_i  input  1  MRET executing this cycle.
REQ-018 irq_ext_i  input  1  external interrupt level.
REQ-019 trap_vector_o  output  32  next PC on trap, combinational from mtvec and cause_i.
REQ-020 mepc_o  output  32  mepc, next PC on MRET.
REQ-021 irq_pending_o  output  1  mstatus.MIE & mie.MEIE & irq_ext_i.

Function
REQ-022 Implemented map: mstatus 0x300 (MIE bit3, MPIE bit7, MPP bits12:11 read 2'b11), mie 0x304 (MEIE bit11 only), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (MEIP bit11 = irq_ext_i, read-only), mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, cycle/h 0xC00/0xC80, instret/h 0xC02/0xC82, mhartid 0xF14 (reads 0); all other bits read 0.
REQ-023 csr_illegal_o = csr_en_i & (unmapped address | (csr_op_i != 00 & csr_addr_i[11:10]==2'b11)).
REQ-024 Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata; committed at next edge only if csr_en_i, op != 00, not illegal, and trap_i = 0.
REQ-025 csr_rdata_o = pre-write value in the access cycle, zero-latency.
REQ-026 mepc writes force bits[1:0] = 0; mtvec writes force bit1 = 0, and bit0 = 0 when VECTORED_EN = 0.
REQ-027 Trap (trap_i=1): mepc <= {pc_i[31:2],2'b00}, mcause <= cause_i, mtval <= tval_i, MPIE <= MIE, MIE <= 0; one cycle.
REQ-028 MRET (mret_i=1, trap_i=0): MIE <= MPIE, MPIE <= 1.
REQ-029 Priority when simultaneous: trap_i > mret_i > CSR write; lower-priority updates dropped.
REQ-030 trap_vector_o = {mtvec[31:2],2'b00} + (mtvec[0] & cause_i[31] ? 4*cause_i[4:0] : 0).
REQ-031 mcycle: 64-bit, +1 every cycle, wraps 2^64-1 -> 0.
REQ-032 minstret: 64-bit, +1 when instret_i, wraps.
REQ-033 CSR write to any counter half takes precedence over that cycle's increment; other half unchanged (no carry into it that cycle).
REQ-034 Low-to-high carry occurs in the same cycle as low wrap (0xFFFF_FFFF -> 0 increments high).

Reset
REQ-035 On rst: mtvec = MTVEC_RESET (masked per REQ-026), all other CSRs and both counters = 0, MIE = MPIE = 0.
REQ-036 rst asserted mid-trap or mid-write aborts the update; state is reset value on deassertion, counting resumes first edge after.

Structure
REQ-037 Package csr_pkg holds CSR address constants, csr_op enum, mstatus bit indices, and standard cause codes.
REQ-038 Sub-module csr_counter64 (64-bit counter with increment enable and per-half write port) instantiated twice.

Verification
REQ-039 Reset with MTVEC_RESET=32'h0000_0100 -> mtvec reads 0x100, mcycle reads 0 first cycle, increments each cycle.
REQ-040 RW 0x340 with 0xDEAD_BEEF, then RS 0x0000_0010, then RC 0xDEAD_0000 -> reads return prior values; final 0x0000_BEFF.
REQ-041 mtvec=0x1001, trap_i with cause 0x8000_000B, pc 0x2006 -> trap_vector_o 0x102C; next cycle mepc 0x2004, mcause 0x8000_000B, MIE 0, MPIE = old MIE.
REQ-042 Same-cycle trap_i, mret_i and RW mscratch -> only trap effects; mscratch unchanged.
REQ-043 Write 0xFFFF_FFFF to mcycle low -> next cycle low 0, high incremented by 1; write to 0xC00 -> csr_illegal_o=1, no change.
REQ-044 MIE=1, MEIE=1, toggle irq_ext_i -> irq_pending_o follows same cycle; mip reads bit11 accordingly.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: address map, operation
// encoding, mstatus/mie/mip bit positions, standard cause codes and the
// read-modify-write helper.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  // CSR instruction operation
  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Bit positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MIE_MEIE       = 11;
  localparam int unsigned MIP_MEIP       = 11;

  // Standard mcause values
  localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'h0000_0000;
  localparam logic [31:0] CAUSE_ILLEGAL_INSN     = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAKPOINT       = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M          = 32'h0000_000B;
  localparam logic [31:0] CAUSE_M_SOFT_IRQ       = 32'h8000_0003;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ      = 32'h8000_0007;
  localparam logic [31:0] CAUSE_M_EXT_IRQ        = 32'h8000_000B;

  // New CSR value produced by a CSR instruction from the old value
  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_value,
                                            input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      CSR_OP_RW: result = operand;
      CSR_OP_RS: result = old_value | operand;
      CSR_OP_RC: result = old_value & ~operand;
      default:   result = old_value;
    endcase
    return result;
  endfunction

  // Exception PCs are always word aligned
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with an increment enable and independent
// 32-bit write ports for each half. A write to either half suppresses the
// increment for that cycle; the low-to-high carry happens on the same edge
// the low half wraps. With ENABLE = 0 the counter stays at zero.
module csr_counter64 #(
  parameter bit ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [31:0] lo;
  logic [31:0] hi;

  // Count, or load the written half while leaving the other half alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo <= '0;
      hi <= '0;
    end else if (ENABLE) begin
      if (wr_lo || wr_hi) begin
        if (wr_lo) lo <= wdata;
        if (wr_hi) hi <= wdata;
      end else if (inc) begin
        lo <= lo + 32'd1;
        if (&lo) hi <= hi + 32'd1;
      end
    end
  end

  assign count = {hi, lo};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write access, trap entry and MRET
// handling for mstatus/mepc/mcause/mtval, trap vector generation, external
// interrupt pending, and the mcycle/minstret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] tval_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  // mtvec bit1 is reserved; bit0 selects vectored mode only when supported
  function automatic logic [31:0] mask_mtvec(input logic [31:0] value);
    logic [31:0] masked;
    masked    = value;
    masked[1] = 1'b0;
    if (!VECTORED_EN) masked[0] = 1'b0;
    return masked;
  endfunction

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_op_e     op;
  logic [31:0] read_value;
  logic        access_mapped;
  logic        illegal;
  logic        write_commit;
  logic [31:0] write_value;
  logic [31:0] vector_offset;

  assign op = csr_op_e'(csr_op_i);

  // Read mux: old value of the addressed CSR, also flags unmapped addresses
  always_comb begin
    read_value    = '0;
    access_mapped = 1'b1;
    case (csr_addr_i)
      ADDR_MSTATUS: begin
        read_value[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        read_value[MSTATUS_MPIE] = mstatus_mpie;
        read_value[MSTATUS_MIE]  = mstatus_mie;
      end
      ADDR_MIE:                     read_value[MIE_MEIE] = mie_meie;
      ADDR_MTVEC:                   read_value = mtvec;
      ADDR_MSCRATCH:                read_value = mscratch;
      ADDR_MEPC:                    read_value = mepc;
      ADDR_MCAUSE:                  read_value = mcause;
      ADDR_MTVAL:                   read_value = mtval;
      ADDR_MIP:                     read_value[MIP_MEIP] = irq_ext_i;
      ADDR_MCYCLE,   ADDR_CYCLE:    read_value = mcycle[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   read_value = mcycle[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  read_value = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: read_value = minstret[63:32];
      ADDR_MHARTID:                 read_value = '0;
      default:                      access_mapped = 1'b0;
    endcase
  end

  // Unmapped addresses and writes to the read-only 0xC00-0xFFF block trap
  assign illegal = csr_en_i &
                   (~access_mapped |
                    ((op != CSR_OP_READ) & (csr_addr_i[11:10] == 2'b11)));

  // A CSR write loses to a trap or an MRET in the same cycle
  assign write_commit = csr_en_i & (op != CSR_OP_READ) & ~illegal &
                        ~trap_i & ~mret_i;
  assign write_value  = csr_apply(op, read_value, csr_wdata_i);

  // mstatus interrupt-enable stack: trap pushes, MRET pops, CSR write loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_i) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (write_commit && csr_addr_i == ADDR_MSTATUS) begin
      mstatus_mie  <= write_value[MSTATUS_MIE];
      mstatus_mpie <= write_value[MSTATUS_MPIE];
    end
  end

  // Trap state: captured on trap entry, otherwise software-writable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
    end else if (trap_i) begin
      mepc   <= align_pc(pc_i);
      mcause <= cause_i;
      mtval  <= tval_i;
    end else if (write_commit) begin
      case (csr_addr_i)
        ADDR_MEPC:   mepc   <= align_pc(write_value);
        ADDR_MCAUSE: mcause <= write_value;
        ADDR_MTVAL:  mtval  <= write_value;
        default: ;
      endcase
    end
  end

  // Software-only configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtvec    <= mask_mtvec(MTVEC_RESET);
      mscratch <= '0;
      mie_meie <= 1'b0;
    end else if (write_commit) begin
      case (csr_addr_i)
        ADDR_MTVEC:    mtvec    <= mask_mtvec(write_value);
        ADDR_MSCRATCH: mscratch <= write_value;
        ADDR_MIE:      mie_meie <= write_value[MIE_MEIE];
        default: ;
      endcase
    end
  end

  csr_counter64 #(
    .ENABLE (COUNTERS_EN)
  ) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (write_commit && csr_addr_i == ADDR_MCYCLE),
    .wr_hi (write_commit && csr_addr_i == ADDR_MCYCLEH),
    .wdata (write_value),
    .count (mcycle)
  );

  csr_counter64 #(
    .ENABLE (COUNTERS_EN)
  ) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_i),
    .wr_lo (write_commit && csr_addr_i == ADDR_MINSTRET),
    .wr_hi (write_commit && csr_addr_i == ADDR_MINSTRETH),
    .wdata (write_value),
    .count (minstret)
  );

  // Vectored mode offsets interrupts by 4 * cause code
  assign vector_offset = (mtvec[0] & cause_i[31]) ? {25'd0, cause_i[4:0], 2'b00}
                                                  : 32'd0;

  assign csr_rdata_o   = read_value;
  assign csr_illegal_o = illegal;
  assign trap_vector_o = {mtvec[31:2], 2'b00} + vector_offset;
  assign mepc_o        = mepc;
  assign irq_pending_o = mstatus_mie & mie_meie & irq_ext_i;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus pushes expected responses, a
// negedge monitor pops and compares whenever a CSR access or probe is shown.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret;
  logic        trap;
  logic [31:0] pc;
  logic [31:0] cause;
  logic [31:0] tval;
  logic        mret;
  logic        irq_ext;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        irq_pending;
  logic        probe;

  typedef struct {
    string       name;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ill;
    logic        chk_tv;
    logic [31:0] tv;
    logic        chk_irq;
    logic        irq;
    logic        chk_mepc;
    logic [31:0] mepc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic        pend_tv_chk = 1'b0;
  logic [31:0] pend_tv = '0;
  logic        pend_irq_chk = 1'b0;
  logic        pend_irq = 1'b0;
  logic        pend_mepc_chk = 1'b0;
  logic [31:0] pend_mepc = '0;

  csr_unit #(
    .MTVEC_RESET (32'h0000_0100),
    .VECTORED_EN (1'b1),
    .COUNTERS_EN (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .csr_en_i      (csr_en),
    .csr_op_i      (csr_op),
    .csr_addr_i    (csr_addr),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .csr_illegal_o (csr_illegal),
    .instret_i     (instret),
    .trap_i        (trap),
    .pc_i          (pc),
    .cause_i       (cause),
    .tval_i        (tval),
    .mret_i        (mret),
    .irq_ext_i     (irq_ext),
    .trap_vector_o (trap_vector),
    .mepc_o        (mepc_out),
    .irq_pending_o (irq_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented response against the scoreboard head
  always @(negedge clk) begin
    if (!rst && (csr_en || probe)) begin
      if (q.size() == 0) begin
        cmp("unexpected_response", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_rd)   cmp({e.name, "_rdata"}, csr_rdata, e.rd);
        cmp({e.name, "_illegal"}, {31'd0, csr_illegal}, {31'd0, e.ill});
        if (e.chk_tv)   cmp({e.name, "_trap_vector"}, trap_vector, e.tv);
        if (e.chk_irq)  cmp({e.name, "_irq_pending"}, {31'd0, irq_pending}, {31'd0, e.irq});
        if (e.chk_mepc) cmp({e.name, "_mepc_o"}, mepc_out, e.mepc);
      end
    end
  end

  task automatic push_exp(input string nm, input logic chk_rd, input logic [31:0] rd,
                          input logic ill);
    exp_t e;
    e.name = nm;      e.chk_rd = chk_rd;     e.rd = rd;        e.ill = ill;
    e.chk_tv = pend_tv_chk;   e.tv = pend_tv;
    e.chk_irq = pend_irq_chk; e.irq = pend_irq;
    e.chk_mepc = pend_mepc_chk; e.mepc = pend_mepc;
    q.push_back(e);
    pend_tv_chk = 1'b0; pend_irq_chk = 1'b0; pend_mepc_chk = 1'b0;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    probe = 1'b0; trap = 1'b0; mret = 1'b0; instret = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic chk_rd, input logic [31:0] rd, input logic ill,
                       input string nm);
    push_exp(nm, chk_rd, rd, ill);
    csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    end_cycle();
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string nm);
    issue(CSR_OP_READ, addr, 32'd0, 1'b1, exp, 1'b0, nm);
  endtask

  task automatic do_probe(input string nm);
    push_exp(nm, 1'b0, 32'd0, 1'b0);
    probe = 1'b1;
    end_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    instret = 1'b0; trap = 1'b0; pc = '0; cause = '0; tval = '0; mret = 1'b0;
    irq_ext = 1'b0; probe = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and free-running mcycle
    rd(ADDR_MCYCLE,  32'd0,         "rst_mcycle0");
    rd(ADDR_MCYCLE,  32'd1,         "rst_mcycle1");
    rd(ADDR_MTVEC,   32'h0000_0100, "rst_mtvec");
    rd(ADDR_MCYCLE,  32'd3,         "rst_mcycle3");
    rd(ADDR_MCYCLEH, 32'd0,         "rst_mcycleh");
    rd(ADDR_MSTATUS, 32'h0000_1800, "rst_mstatus");
    rd(ADDR_MEPC,    32'd0,         "rst_mepc");
    rd(ADDR_MHARTID, 32'd0,         "mhartid");

    // RW / RS / RC on mscratch
    issue(CSR_OP_RW, ADDR_MSCRATCH, 32'hDEAD_BEEF, 1'b1, 32'd0,         1'b0, "mscratch_rw");
    issue(CSR_OP_RS, ADDR_MSCRATCH, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, "mscratch_rs");
    issue(CSR_OP_RC, ADDR_MSCRATCH, 32'hDEAD_0000, 1'b1, 32'hDEAD_BEFF, 1'b0, "mscratch_rc");
    rd(ADDR_MSCRATCH, 32'h0000_BEFF, "mscratch_final");

    // Enable MIE, program vectored mtvec (bit1 must be masked)
    issue(CSR_OP_RW, ADDR_MSTATUS, 32'h0000_0008, 1'b1, 32'h0000_1800, 1'b0, "mstatus_set");
    rd(ADDR_MSTATUS, 32'h0000_1808, "mstatus_mie1");
    issue(CSR_OP_RW, ADDR_MTVEC, 32'h0000_1003, 1'b1, 32'h0000_0100, 1'b0, "mtvec_wr");
    rd(ADDR_MTVEC, 32'h0000_1001, "mtvec_masked");
    cause = CAUSE_ILLEGAL_INSN;
    pend_tv_chk = 1'b1; pend_tv = 32'h0000_1000;
    do_probe("tvec_exception");

    // Trap + MRET + mscratch write in one cycle: trap wins
    trap = 1'b1; mret = 1'b1; cause = CAUSE_M_EXT_IRQ; pc = 32'h0000_2006; tval = 32'h0000_0055;
    pend_tv_chk = 1'b1; pend_tv = 32'h0000_102C;
    issue(CSR_OP_RW, ADDR_MSCRATCH, 32'h1234_5678, 1'b1, 32'h0000_BEFF, 1'b0, "trap_cycle");
    pend_mepc_chk = 1'b1; pend_mepc = 32'h0000_2004;
    rd(ADDR_MEPC,     32'h0000_2004, "trap_mepc");
    rd(ADDR_MCAUSE,   32'h8000_000B, "trap_mcause");
    rd(ADDR_MTVAL,    32'h0000_0055, "trap_mtval");
    rd(ADDR_MSTATUS,  32'h0000_1880, "trap_mstatus");
    rd(ADDR_MSCRATCH, 32'h0000_BEFF, "trap_mscratch");

    // MRET beats a same-cycle CSR write
    mret = 1'b1;
    issue(CSR_OP_RW, ADDR_MSCRATCH, 32'h0000_AAAA, 1'b1, 32'h0000_BEFF, 1'b0, "mret_cycle");
    rd(ADDR_MSTATUS,  32'h0000_1888, "mret_mstatus");
    rd(ADDR_MSCRATCH, 32'h0000_BEFF, "mret_mscratch");

    // mepc write alignment
    issue(CSR_OP_RW, ADDR_MEPC, 32'h0000_1237, 1'b1, 32'h0000_2004, 1'b0, "mepc_wr");
    rd(ADDR_MEPC, 32'h0000_1234, "mepc_aligned");

    // External interrupt pending path
    issue(CSR_OP_RW, ADDR_MIE, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, "mie_wr");
    pend_irq_chk = 1'b1; pend_irq = 1'b0;
    rd(ADDR_MIE, 32'h0000_0800, "mie_meie");
    irq_ext = 1'b1;
    pend_irq_chk = 1'b1; pend_irq = 1'b1;
    rd(ADDR_MIP, 32'h0000_0800, "mip_high");
    irq_ext = 1'b0;
    pend_irq_chk = 1'b1; pend_irq = 1'b0;
    rd(ADDR_MIP, 32'd0, "mip_low");
    irq_ext = 1'b1;
    pend_irq_chk = 1'b1; pend_irq = 1'b1;
    issue(CSR_OP_RC, ADDR_MSTATUS, 32'h0000_0008, 1'b1, 32'h0000_1888, 1'b0, "mie_clear");
    pend_irq_chk = 1'b1; pend_irq = 1'b0;
    do_probe("irq_masked");
    irq_ext = 1'b0;

    // minstret counting, hi-write precedence over increment
    instret = 1'b1; end_cycle();
    instret = 1'b1; end_cycle();
    instret = 1'b1; end_cycle();
    rd(ADDR_MINSTRET, 32'd3, "minstret3");
    issue(CSR_OP_RW, ADDR_INSTRET, 32'h55, 1'b1, 32'd3, 1'b1, "instret_ro_wr");
    rd(ADDR_INSTRET, 32'd3, "instret_ro_read");
    instret = 1'b1;
    issue(CSR_OP_RW, ADDR_MINSTRETH, 32'd9, 1'b1, 32'd0, 1'b0, "minstreth_wr");
    rd(ADDR_MINSTRET,  32'd3, "minstret_held");
    rd(ADDR_MINSTRETH, 32'd9, "minstreth_val");
    issue(CSR_OP_RW, ADDR_MINSTRET, 32'hFFFF_FFFF, 1'b1, 32'd3, 1'b0, "minstret_wr");
    instret = 1'b1;
    rd(ADDR_MINSTRET,  32'hFFFF_FFFF, "minstret_pre_wrap");
    rd(ADDR_MINSTRET,  32'd0,         "minstret_wrapped");
    rd(ADDR_MINSTRETH, 32'd10,        "minstreth_carry");

    // Illegal accesses
    issue(CSR_OP_READ, 12'h7C0, 32'd0, 1'b1, 32'd0, 1'b1, "unmapped");
    issue(CSR_OP_RS,   ADDR_MHARTID, 32'd1, 1'b1, 32'd0, 1'b1, "mhartid_wr");

    // mcycle low wrap carries into high
    issue(CSR_OP_RW, ADDR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, "mcycle_wr");
    rd(ADDR_MCYCLE,  32'hFFFF_FFFF, "mcycle_pre_wrap");
    rd(ADDR_MCYCLE,  32'd0,         "mcycle_wrapped");
    rd(ADDR_MCYCLEH, 32'd1,         "mcycleh_carry");
    issue(CSR_OP_RW, ADDR_CYCLE, 32'd0, 1'b0, 32'd0, 1'b1, "cycle_ro_wr");
    rd(ADDR_CYCLEH,  32'd1,         "cycleh_unchanged");
    issue(CSR_OP_RW, ADDR_MCYCLEH, 32'd7, 1'b1, 32'd1, 1'b0, "mcycleh_wr");
    rd(ADDR_MCYCLEH, 32'd7,         "mcycleh_val");

    // Reset asserted during a write aborts it
    push_exp("abort_wr", 1'b1, 32'h0000_BEFF, 1'b0);
    csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = ADDR_MSCRATCH; csr_wdata = 32'h77;
    @(negedge clk);
    #1 rst = 1'b1;
    end_cycle();
    @(posedge clk);
    #1 rst = 1'b0;
    rd(ADDR_MCYCLE,    32'd0,         "rst2_mcycle0");
    rd(ADDR_MSCRATCH,  32'd0,         "rst2_mscratch");
    rd(ADDR_MCYCLE,    32'd2,         "rst2_mcycle2");
    rd(ADDR_MTVEC,     32'h0000_0100, "rst2_mtvec");
    rd(ADDR_MSTATUS,   32'h0000_1800, "rst2_mstatus");
    rd(ADDR_MINSTRETH, 32'd0,         "rst2_minstreth");

    repeat (2) end_cycle();
    cmp("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
